// File: rtl/pb_debounce.sv
`default_nettype none
// ============================================================================
// Module   : pb_debounce
// Purpose  : Push-button synchroniser/debouncer with press/release strobes,
//            optional auto-repeat (PB_AUTOREPEAT_EN) and a 4-bit press counter.
// Revision : 1.0
// ============================================================================
module pb_debounce #(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] pb_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [3:0]       press_count
);

    localparam int                 c_CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

`ifdef PB_AUTOREPEAT_EN
    localparam int                 c_RPT_TOP   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int                 c_RPT_W     = $clog2(c_RPT_TOP + 1);
    localparam logic [c_RPT_W-1:0] c_DELAY_MAX = c_RPT_W'(REPEAT_DELAY - 1);
    localparam logic [c_RPT_W-1:0] c_RATE_MAX  = c_RPT_W'(REPEAT_RATE - 1);
    localparam logic [c_RPT_W-1:0] c_RPT_ONE   = c_RPT_W'(1);
`endif

    typedef enum logic [1:0] {
        ST_UP     = 2'd0,
        ST_DOWN   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    logic [N_BTN-1:0] w_level;
    logic [N_BTN-1:0] w_press;
    logic [N_BTN-1:0] w_release;

    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_btn
            logic               r_sync1;
            logic               r_sync2;
            logic [c_CNT_W-1:0] r_cnt;
            state_t             r_state;
            logic               r_level;
            logic               r_press;
            logic               r_release;
            logic               w_differ;
            logic               w_flip;
`ifdef PB_AUTOREPEAT_EN
            logic [c_RPT_W-1:0] r_rpt;
`endif

            assign w_differ = r_sync2 ^ r_level;
            assign w_flip   = w_differ && (r_cnt == c_CNT_MAX);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                end else begin
                    r_sync1 <= pb_raw[gi];
                    r_sync2 <= r_sync1;
                end
            end

            // Counts consecutive cycles of disagreement; any agreeing cycle restarts the run.
            always_ff @(posedge clk) begin
                if (rst || !w_differ || w_flip) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_state   <= ST_UP;
                    r_level   <= 1'b0;
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
`ifdef PB_AUTOREPEAT_EN
                    r_rpt     <= '0;
`endif
                end else begin
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                    case (r_state)
                        ST_UP: begin
                            if (w_flip) begin
                                r_state <= ST_DOWN;
                                r_level <= 1'b1;
                                r_press <= 1'b1;
`ifdef PB_AUTOREPEAT_EN
                                r_rpt   <= '0;
`endif
                            end
                        end
                        ST_DOWN: begin
                            // A debounced release always wins over a coincident repeat tick.
                            if (w_flip) begin
                                r_state   <= ST_UP;
                                r_level   <= 1'b0;
                                r_release <= 1'b1;
`ifdef PB_AUTOREPEAT_EN
                            end else if (r_rpt == c_DELAY_MAX) begin
                                r_state <= ST_REPEAT;
                                r_press <= 1'b1;
                                r_rpt   <= '0;
                            end else begin
                                r_rpt <= r_rpt + c_RPT_ONE;
`endif
                            end
                        end
`ifdef PB_AUTOREPEAT_EN
                        ST_REPEAT: begin
                            if (w_flip) begin
                                r_state   <= ST_UP;
                                r_level   <= 1'b0;
                                r_release <= 1'b1;
                            end else if (r_rpt == c_RATE_MAX) begin
                                r_press <= 1'b1;
                                r_rpt   <= '0;
                            end else begin
                                r_rpt <= r_rpt + c_RPT_ONE;
                            end
                        end
`endif
                        default: begin
                            r_state <= ST_UP;
                            r_level <= 1'b0;
                        end
                    endcase
                end
            end

            assign w_level[gi]   = r_level;
            assign w_press[gi]   = r_press;
            assign w_release[gi] = r_release;
        end
    endgenerate

    logic [3:0] r_press_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_press_count <= 4'd0;
        end else if (w_press[0]) begin
            r_press_count <= r_press_count + 4'd1;
        end
    end

    assign btn_level   = w_level;
    assign btn_press   = w_press;
    assign btn_release = w_release;
    assign press_count = r_press_count;

endmodule
`default_nettype wire

// File: tb/tb_pb_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_pb_debounce
// Purpose  : Self-checking bench for pb_debounce with a window-based model.
// Revision : 1.0
// ============================================================================
module tb_pb_debounce;

    localparam int N_BTN = 2;
    localparam int DEB   = 4;
    localparam int RD    = 20;
    localparam int RR    = 8;
`ifdef PB_AUTOREPEAT_EN
    localparam bit c_RPT = 1'b1;
`else
    localparam bit c_RPT = 1'b0;
`endif
    localparam logic [63:0] c_MASK = (64'd1 << DEB) - 64'd1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N_BTN-1:0] pb_raw = '0;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [3:0]       press_count;

    pb_debounce #(
        .N_BTN          (N_BTN),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pb_raw     (pb_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .press_count(press_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference: a level flips once the last DEB synchronised samples all disagree with it.
    int               m_cyc = 0;
    bit               m_s1 [N_BTN];
    bit               m_s2 [N_BTN];
    logic [63:0]      m_hist [N_BTN];
    int               m_t0 [N_BTN];
    logic [N_BTN-1:0] e_lvl   = '0;
    logic [N_BTN-1:0] e_press = '0;
    logic [N_BTN-1:0] e_rel   = '0;
    logic [3:0]       e_cnt   = 4'd0;

    function automatic void model_step();
        bit flip;
        m_cyc++;
        if (rst) begin
            for (int b = 0; b < N_BTN; b++) begin
                m_s1[b] = 1'b0; m_s2[b] = 1'b0; m_hist[b] = '0; m_t0[b] = 0;
            end
            e_lvl = '0; e_press = '0; e_rel = '0; e_cnt = 4'd0;
            return;
        end
        e_cnt = e_cnt + {3'b000, e_press[0]};
        for (int b = 0; b < N_BTN; b++) begin
            m_hist[b] = {m_hist[b][62:0], m_s2[b]};
            flip = ((m_hist[b] & c_MASK) == (e_lvl[b] ? 64'd0 : c_MASK));
            e_press[b] = 1'b0;
            e_rel[b]   = 1'b0;
            if (flip) begin
                e_lvl[b] = ~e_lvl[b];
                if (e_lvl[b]) begin
                    e_press[b] = 1'b1;
                    m_t0[b]    = m_cyc;
                end else begin
                    e_rel[b] = 1'b1;
                end
            end else if (c_RPT && e_lvl[b] && (m_cyc - m_t0[b]) >= RD &&
                         ((m_cyc - m_t0[b] - RD) % RR) == 0) begin
                e_press[b] = 1'b1;
            end
            m_s2[b] = m_s1[b];
            m_s1[b] = pb_raw[b];
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        int hit = -1;
        rst = 1'b1; pb_raw = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if ({btn_level, btn_press, btn_release, press_count} !== 10'd0) begin
                n_err++;
                $display("FAIL reset_outputs got %b_%b_%b_%h exp all zero", btn_level, btn_press, btn_release, press_count);
            end
        end
        rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_vec++;
            if ({btn_level, btn_press, btn_release, press_count} !== {e_lvl, e_press, e_rel, e_cnt}) begin
                n_err++;
                $display("FAIL reset_model cyc=%0d got %b_%b_%b_%h exp %b_%b_%b_%h", m_cyc,
                         btn_level, btn_press, btn_release, press_count, e_lvl, e_press, e_rel, e_cnt);
            end
            if (btn_press == 2'b11 && hit < 0) hit = i;
        end
        n_vec++;
        if (hit !== 6) begin
            n_err++;
            $display("FAIL reset_redetect press at cycle %0d, required 6", hit);
        end
    endtask

    task automatic test_glitch();
        int presses = 0;
        int lvl_seen = 0;
        rst = 1'b1; pb_raw = 2'b00; tick(); rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            pb_raw[0] = (i < 20) && ((i / 2) % 2 == 0);
            tick();
            n_vec++;
            if ({btn_level, btn_press, btn_release, press_count} !== {e_lvl, e_press, e_rel, e_cnt}) begin
                n_err++;
                $display("FAIL glitch_model cyc=%0d got %b_%b_%b_%h exp %b_%b_%b_%h", m_cyc,
                         btn_level, btn_press, btn_release, press_count, e_lvl, e_press, e_rel, e_cnt);
            end
            presses  += int'(btn_press[0]);
            lvl_seen += int'(btn_level[0]);
        end
        n_vec++;
        if (presses != 0 || lvl_seen != 0 || press_count !== 4'd0) begin
            n_err++;
            $display("FAIL glitch_filter presses=%0d level_cycles=%0d count=%0d, required 0/0/0", presses, lvl_seen, press_count);
        end
    endtask

    task automatic test_clean_press();
        int p_at = -1, r_at = -1, p_n = 0, r_n = 0;
        rst = 1'b1; pb_raw = 2'b00; tick(); rst = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            pb_raw[0] = (i <= 10);
            tick();
            n_vec++;
            if ({btn_level, btn_press, btn_release, press_count} !== {e_lvl, e_press, e_rel, e_cnt}) begin
                n_err++;
                $display("FAIL press_model cyc=%0d got %b_%b_%b_%h exp %b_%b_%b_%h", m_cyc,
                         btn_level, btn_press, btn_release, press_count, e_lvl, e_press, e_rel, e_cnt);
            end
            if (btn_press[0])   begin p_n++; if (p_at < 0) p_at = i; end
            if (btn_release[0]) begin r_n++; if (r_at < 0) r_at = i; end
        end
        n_vec++;
        if (p_at != 6 || r_at != 16 || p_n != 1 || r_n != 1 || press_count !== 4'd1) begin
            n_err++;
            $display("FAIL clean_press press@%0d rel@%0d np=%0d nr=%0d cnt=%0d, required 6/16/1/1/1",
                     p_at, r_at, p_n, r_n, press_count);
        end
    endtask

    task automatic test_wrap();
        rst = 1'b1; pb_raw = 2'b00; tick(); rst = 1'b0;
        for (int k = 0; k < 20 * 14; k++) begin
            pb_raw = (k < 17 * 14) ? {1'b0, ((k % 14) < 7)} : {((k % 14) < 7), 1'b0};
            tick();
            n_vec++;
            if ({btn_level, btn_press, btn_release, press_count} !== {e_lvl, e_press, e_rel, e_cnt}) begin
                n_err++;
                $display("FAIL wrap_model cyc=%0d got %b_%b_%b_%h exp %b_%b_%b_%h", m_cyc,
                         btn_level, btn_press, btn_release, press_count, e_lvl, e_press, e_rel, e_cnt);
            end
            if (k == 17 * 14 - 1 || k == 20 * 14 - 1) begin
                n_vec++;
                if (press_count !== 4'd1) begin
                    n_err++;
                    $display("FAIL wrap_count at k=%0d got %0d, required 1", k, press_count);
                end
            end
        end
    endtask

    task automatic test_autorepeat();
        int offs[$];
        int p0 = -1, rel_off = -1;
        int exp_offs[$];
        rst = 1'b1; pb_raw = 2'b00; tick(); rst = 1'b0;
        pb_raw[0] = 1'b1;
        for (int i = 1; i <= 80; i++) begin
            if (p0 >= 0 && i == p0 + 45) pb_raw[0] = 1'b0;
            tick();
            n_vec++;
            if ({btn_level, btn_press, btn_release, press_count} !== {e_lvl, e_press, e_rel, e_cnt}) begin
                n_err++;
                $display("FAIL repeat_model cyc=%0d got %b_%b_%b_%h exp %b_%b_%b_%h", m_cyc,
                         btn_level, btn_press, btn_release, press_count, e_lvl, e_press, e_rel, e_cnt);
            end
            if (btn_press[0]) begin
                if (p0 < 0) p0 = i;
                offs.push_back(i - p0);
            end
            if (btn_release[0] && rel_off < 0 && p0 >= 0) rel_off = i - p0;
        end
        if (c_RPT) exp_offs = '{0, 20, 28, 36, 44};
        else       exp_offs = '{0};
        n_vec++;
        if (offs.size() != exp_offs.size()) begin
            n_err++;
            $display("FAIL repeat_strobes got %0d strobes, required %0d", offs.size(), exp_offs.size());
        end else begin
            for (int j = 0; j < offs.size(); j++) begin
                n_vec++;
                if (offs[j] != exp_offs[j]) begin
                    n_err++;
                    $display("FAIL repeat_offset idx=%0d got +%0d, required +%0d", j, offs[j], exp_offs[j]);
                end
            end
        end
        n_vec++;
        if (press_count !== (c_RPT ? 4'd5 : 4'd1) || rel_off != 50) begin
            n_err++;
            $display("FAIL repeat_count cnt=%0d rel@+%0d, required %0d / +50", press_count, rel_off, c_RPT ? 5 : 1);
        end
    endtask

    task automatic test_reset_mid_hold();
        int p_at = -1, r_n = 0;
        rst = 1'b1; pb_raw = 2'b00; tick(); rst = 1'b0;
        pb_raw[0] = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        n_vec++;
        if (btn_level[0] !== 1'b1) begin
            n_err++;
            $display("FAIL midhold_setup level got %b, required 1", btn_level[0]);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        n_vec++;
        if ({btn_level, btn_press, btn_release, press_count} !== 10'd0) begin
            n_err++;
            $display("FAIL midhold_clear got %b_%b_%b_%h exp all zero", btn_level, btn_press, btn_release, press_count);
        end
        for (int i = 1; i <= 12; i++) begin
            tick();
            n_vec++;
            if ({btn_level, btn_press, btn_release, press_count} !== {e_lvl, e_press, e_rel, e_cnt}) begin
                n_err++;
                $display("FAIL midhold_model cyc=%0d got %b_%b_%b_%h exp %b_%b_%b_%h", m_cyc,
                         btn_level, btn_press, btn_release, press_count, e_lvl, e_press, e_rel, e_cnt);
            end
            if (btn_press[0] && p_at < 0) p_at = i;
            r_n += int'(btn_release[0]);
        end
        n_vec++;
        if (p_at != 6 || r_n != 0) begin
            n_err++;
            $display("FAIL midhold_redetect press@%0d releases=%0d, required 6/0", p_at, r_n);
        end
    endtask

    task automatic test_random();
        logic [1:0] v;
        int len;
        int cyc = 0;
        rst = 1'b1; pb_raw = 2'b00; tick(); rst = 1'b0;
        while (cyc < 900) begin
            v   = 2'($urandom);
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 45)) : int'($urandom_range(1, 6));
            for (int j = 0; j < len; j++) begin
                rst    = ($urandom_range(0, 299) == 0);
                pb_raw = v;
                tick();
                cyc++;
                n_vec++;
                if ({btn_level, btn_press, btn_release, press_count} !== {e_lvl, e_press, e_rel, e_cnt}) begin
                    n_err++;
                    $display("FAIL random_model cyc=%0d got %b_%b_%b_%h exp %b_%b_%b_%h", m_cyc,
                             btn_level, btn_press, btn_release, press_count, e_lvl, e_press, e_rel, e_cnt);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_clean_press();
        test_wrap();
        test_autorepeat();
        test_reset_mid_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
